// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants: state encoding, NOP word, datapath width, PC stride.
package mips_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack bus: the fetch stage is master, the memory is slave.
interface if_fetch_stage_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_pc_reg.sv
// Program counter: async reset, +4 increment, word-aligned redirect (wins over increment), else hold.
module if_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i & ~32'd3;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem req/ack bus, resolves stalls/flushes
// for an always-enabled IF/ID register. Define IF_FETCH_PERF_EN to add fetch/stall/flush counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_in,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            instruction_reg_out,
  output logic                   instr_valid,
  output logic [31:0]            pc_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt
`endif
);
  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  kill_addr_q, kill_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  pc;
  logic         pc_inc;
  logic         req;

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clock      (clock),
    .reset      (reset),
    .inc_i      (pc_inc),
    .redirect_i (branch_taken),
    .target_i   (branch_target),
    .pc_o       (pc)
  );

  always_comb begin
    state_d     = state_q;
    kill_addr_d = kill_addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_out_d    = pc_out_q;
    pc_inc      = 1'b0;
    req         = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          instr_d  = imem.imem_rdata;
          valid_d  = 1'b1;
          pc_out_d = pc;
          pc_inc   = 1'b1;
          state_d  = stall_in ? S_HOLD : S_REQ;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_in) begin
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        // Wrong-path request still in flight: keep bus stable and swallow its data.
        req     = 1'b1;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (imem.imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides everything above, including a stall or an arriving ack.
    if (branch_taken) begin
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      pc_out_d = pc_out_q;
      pc_inc   = 1'b0;
      case (state_q)
        S_REQ: begin
          if (!imem.imem_ack) begin
            state_d     = S_KILL;
            kill_addr_d = pc;
          end else begin
            state_d = S_REQ;
          end
        end
        S_KILL:  state_d = imem.imem_ack ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kill_addr_q <= RESET_PC;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      pc_out_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      kill_addr_q <= kill_addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign imem.imem_req       = req;
  assign imem.imem_addr      = (state_q == S_KILL) ? kill_addr_q : pc;
  assign instruction_reg_out = instr_q;
  assign instr_valid         = valid_q;
  assign pc_out              = pc_out_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (state_q == S_REQ && imem.imem_ack && !branch_taken) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (state_q == S_HOLD) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_taken) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a transaction-level model predicts bus and IF/ID output per cycle.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instruction_reg_out;
  logic        instr_valid;
  logic [31:0] pc_out;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  if_fetch_stage_if imem ();

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clock               (clock),
    .reset               (reset),
    .stall_in            (stall_in),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .imem                (imem),
    .instruction_reg_out (instruction_reg_out),
    .instr_valid         (instr_valid),
    .pc_out              (pc_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt      (perf_fetch_cnt),
    .perf_stall_cnt      (perf_stall_cnt),
    .perf_flush_cnt      (perf_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Bus expectation for the current cycle plus the IF/ID contents expected after the next edge.
  typedef struct {
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] f_cnt;
    logic [31:0] s_cnt;
    logic [31:0] b_cnt;
  } ent_t;

  ent_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference-model state
  logic [31:0] model_pc, cur_addr, out_instr, out_pc;
  logic [31:0] f_cnt, s_cnt, b_cnt;
  logic        out_valid, holding, kill_pending, outstanding;
  int          wait_cnt, lat, lat_max, p_stall, p_br;
  logic        br_next;
  logic [31:0] tgt_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endfunction

  task automatic model_init();
    model_pc = RST_PC; out_instr = NOP; out_pc = RST_PC; out_valid = 1'b0;
    holding = 1'b0; kill_pending = 1'b0; outstanding = 1'b0; wait_cnt = 0; lat = 0;
    f_cnt = 0; s_cnt = 0; b_cnt = 0;
  endtask

  task automatic do_reset();
    ent_t e;
    @(posedge clock); #1;
    reset = 1'b1; stall_in = 1'b0; branch_taken = 1'b0; imem.imem_ack = 1'b0;
    sb_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    model_init();
    e.exp_req = 1'b0; e.exp_addr = RST_PC;
    e.o_valid = 1'b0; e.o_instr = NOP; e.o_pc = RST_PC;
    e.f_cnt = 0; e.s_cnt = 0; e.b_cnt = 0;
    sb_q.push_back(e);
  endtask

  task automatic step();
    ent_t e;
    logic ack, acc, hold_before;
    logic [31:0] tgt;
    @(posedge clock); #1;
    e.exp_req  = !holding;
    e.exp_addr = 32'h0;
    ack = 1'b0;
    if (e.exp_req) begin
      if (!outstanding) begin
        outstanding = 1'b1; cur_addr = model_pc; wait_cnt = 0;
        lat = int'($urandom_range(lat_max, 0));
      end
      e.exp_addr = cur_addr;
      if (wait_cnt == lat) begin ack = 1'b1; outstanding = 1'b0; end
      else wait_cnt++;
    end
    stall_in = ($urandom_range(99, 0) < p_stall);
    branch_taken = br_next || ($urandom_range(99, 0) < p_br);
    case ($urandom_range(2, 0))
      0:       tgt = $urandom;
      1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: tgt = $urandom & 32'h0000_01FF;
    endcase
    if (br_next) tgt = tgt_next;
    br_next = 1'b0;
    branch_target = tgt;
    imem.imem_ack = ack;
    imem.imem_rdata = ack ? mem_word(cur_addr) : $urandom;

    hold_before = holding;
    acc = ack && !branch_taken && !kill_pending;
    if (hold_before) s_cnt++;
    if (ack) begin
      if (acc) begin
        out_valid = 1'b1; out_instr = mem_word(cur_addr); out_pc = cur_addr;
        model_pc = model_pc + 32'd4; f_cnt++; holding = stall_in;
      end
      kill_pending = 1'b0;
    end
    if (branch_taken) begin
      b_cnt++;
      if (e.exp_req && !ack) kill_pending = 1'b1;
      holding = 1'b0; out_valid = 1'b0; out_instr = NOP;
      model_pc = tgt & ~32'd3;
    end else if (hold_before) begin
      holding = stall_in;
    end else if (!acc) begin
      out_valid = 1'b0; out_instr = NOP;
    end
    e.o_valid = out_valid; e.o_instr = out_instr; e.o_pc = out_pc;
    e.f_cnt = f_cnt; e.s_cnt = s_cnt; e.b_cnt = b_cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: consumes one scoreboard entry per cycle, away from the active edge.
  ent_t prev;
  logic have_prev = 1'b0;
  always @(negedge clock) begin
    ent_t e;
    if (reset) begin
      have_prev = 1'b0;
      chk("rst_req",   {31'd0, imem.imem_req}, 32'd0);
      chk("rst_addr",  imem.imem_addr, RST_PC);
      chk("rst_instr", instruction_reg_out, NOP);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc",    pc_out, RST_PC);
    end else if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("imem_req", {31'd0, imem.imem_req}, {31'd0, e.exp_req});
      if (e.exp_req) chk("imem_addr", imem.imem_addr, e.exp_addr);
      if (have_prev) begin
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, prev.o_valid});
        chk("instr_out", instruction_reg_out, prev.o_instr);
        if (prev.o_valid) chk("pc_out", pc_out, prev.o_pc);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, prev.f_cnt);
        chk("perf_stall", perf_stall_cnt, prev.s_cnt);
        chk("perf_flush", perf_flush_cnt, prev.b_cnt);
`endif
      end
      prev = e;
      have_prev = 1'b1;
    end
  end

  initial begin
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
    br_next = 1'b0; tgt_next = 32'h0;
    lat_max = 0; p_stall = 0; p_br = 0;
    model_init();
    do_reset();
    repeat (8) step();                                   // zero-wait streaming
    p_stall = 40; repeat (20) step();                    // stalls with zero-wait memory
    p_stall = 0; lat_max = 2; repeat (20) step();        // slow memory, bubbles
    br_next = 1'b1; tgt_next = 32'h0000_0103;
    repeat (20) step();                                  // redirect while request in flight
    lat_max = 3; repeat (3) step();
    do_reset();                                          // reset mid-request
    lat_max = 0; repeat (10) step();
    br_next = 1'b1; tgt_next = 32'hFFFF_FFFC;
    repeat (10) step();                                  // PC wrap
    lat_max = 3; p_stall = 25; p_br = 8;
    repeat (2000) step();
    lat_max = 0; p_stall = 30; p_br = 15;
    repeat (500) step();
    @(negedge clock); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
